// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller driving a prescaler and a tenths/sec/min time cascade.
// Optional hours field enabled by defining STOPWATCH_HOURS_EN.
module stopwatch_ctrl #(
   parameter logic [31:0] TICK_LIMIT = 32'd4999999
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start_stop,
   input  logic       i_lap,
   input  logic       i_clear,
   output logic [1:0] o_state,
   output logic       o_tick,
   output logic [3:0] o_tenths,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
`ifdef STOPWATCH_HOURS_EN
   output logic [6:0] o_hour,
`endif
   output logic       o_wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        do_latch;
   logic        do_clear;
   logic        counting;
   logic [31:0] presc;

   logic [3:0]  tenths;
   logic [3:0]  tenths_nxt;
   logic [3:0]  lat_tenths;
   logic [5:0]  sec;
   logic [5:0]  sec_nxt;
   logic [5:0]  lat_sec;
   logic [5:0]  min;
   logic [5:0]  min_nxt;
   logic [5:0]  lat_min;
`ifdef STOPWATCH_HOURS_EN
   logic [6:0]  hour;
   logic [6:0]  hour_nxt;
   logic [6:0]  lat_hour;
`endif
   logic        wrap_nxt;

   assign counting = (state == RUN) || (state == LAP);
   assign o_tick   = counting && (presc == TICK_LIMIT);

   // A clear request in RUN/LAP is a no-op, so it does not mask start_stop or lap there.
   always_comb begin
      state_nxt = state;
      do_latch  = 1'b0;
      do_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (i_clear)           state_nxt = IDLE;
            else if (i_start_stop) state_nxt = RUN;
         end
         RUN: begin
            if (i_start_stop) state_nxt = PAUSE;
            else if (i_lap) begin
               state_nxt = LAP;
               do_latch  = 1'b1;
            end
         end
         LAP: begin
            if (i_start_stop) state_nxt = PAUSE;
            else if (i_lap)   state_nxt = RUN;
         end
         PAUSE: begin
            if (i_clear) begin
               state_nxt = IDLE;
               do_clear  = 1'b1;
            end else if (i_start_stop) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tenths_nxt = tenths;
      sec_nxt    = sec;
      min_nxt    = min;
`ifdef STOPWATCH_HOURS_EN
      hour_nxt   = hour;
`endif
      wrap_nxt   = 1'b0;
      if (o_tick) begin
         if (tenths == 4'd9) begin
            tenths_nxt = 4'd0;
            if (sec == 6'd59) begin
               sec_nxt = 6'd0;
               if (min == 6'd59) begin
                  min_nxt = 6'd0;
`ifdef STOPWATCH_HOURS_EN
                  if (hour == 7'd99) begin
                     hour_nxt = 7'd0;
                     wrap_nxt = 1'b1;
                  end else begin
                     hour_nxt = hour + 7'd1;
                  end
`else
                  wrap_nxt = 1'b1;
`endif
               end else begin
                  min_nxt = min + 6'd1;
               end
            end else begin
               sec_nxt = sec + 6'd1;
            end
         end else begin
            tenths_nxt = tenths + 4'd1;
         end
      end
   end

   // The lap latch captures the post-edge live time so a coincident tick is included.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         presc      <= 32'd0;
         tenths     <= 4'd0;
         sec        <= 6'd0;
         min        <= 6'd0;
         lat_tenths <= 4'd0;
         lat_sec    <= 6'd0;
         lat_min    <= 6'd0;
`ifdef STOPWATCH_HOURS_EN
         hour       <= 7'd0;
         lat_hour   <= 7'd0;
`endif
         o_wrap     <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_wrap <= wrap_nxt;
         if (do_clear) begin
            presc      <= 32'd0;
            tenths     <= 4'd0;
            sec        <= 6'd0;
            min        <= 6'd0;
            lat_tenths <= 4'd0;
            lat_sec    <= 6'd0;
            lat_min    <= 6'd0;
`ifdef STOPWATCH_HOURS_EN
            hour       <= 7'd0;
            lat_hour   <= 7'd0;
`endif
         end else begin
            if (counting) presc <= o_tick ? 32'd0 : presc + 32'd1;
            tenths <= tenths_nxt;
            sec    <= sec_nxt;
            min    <= min_nxt;
`ifdef STOPWATCH_HOURS_EN
            hour   <= hour_nxt;
`endif
            if (do_latch) begin
               lat_tenths <= tenths_nxt;
               lat_sec    <= sec_nxt;
               lat_min    <= min_nxt;
`ifdef STOPWATCH_HOURS_EN
               lat_hour   <= hour_nxt;
`endif
            end
         end
      end
   end

   assign o_state  = state;
   assign o_tenths = (state == LAP) ? lat_tenths : tenths;
   assign o_sec    = (state == LAP) ? lat_sec    : sec;
   assign o_min    = (state == LAP) ? lat_min    : min;
`ifdef STOPWATCH_HOURS_EN
   assign o_hour   = (state == LAP) ? lat_hour   : hour;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized self-checking bench for stopwatch_ctrl against a tenths-count reference model.
module tb_stopwatch_ctrl;

   localparam int TL = 1;
`ifdef STOPWATCH_HOURS_EN
   localparam int MAXT = 100 * 36000 - 1;
`else
   localparam int MAXT = 36000 - 1;
`endif

   logic       clk;
   logic       i_rst;
   logic       i_start_stop;
   logic       i_lap;
   logic       i_clear;
   logic [1:0] o_state;
   logic       o_tick;
   logic [3:0] o_tenths;
   logic [5:0] o_sec;
   logic [5:0] o_min;
`ifdef STOPWATCH_HOURS_EN
   logic [6:0] o_hour;
`endif
   logic       o_wrap;

   int total = 0;
   int bad   = 0;

   // Reference model: state 0=IDLE 1=RUN 2=PAUSE 3=LAP, time as total tenths elapsed.
   int m_state = 0;
   int m_presc = 0;
   int m_t     = 0;
   int m_lat   = 0;
   int m_wrap  = 0;
   int m_wraps = 0;
   int seen_wraps = 0;

   stopwatch_ctrl #(.TICK_LIMIT(TL)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start_stop(i_start_stop),
      .i_lap       (i_lap),
      .i_clear     (i_clear),
      .o_state     (o_state),
      .o_tick      (o_tick),
      .o_tenths    (o_tenths),
      .o_sec       (o_sec),
      .o_min       (o_min),
`ifdef STOPWATCH_HOURS_EN
      .o_hour      (o_hour),
`endif
      .o_wrap      (o_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit model_tick_now();
      return ((m_state == 1) || (m_state == 3)) && (m_presc == TL);
   endfunction

   task automatic model_step(input bit rst, input bit ss, input bit lp, input bit clr);
      bit tk;
      int nt, np, ns, nl, w;
      if (rst) begin
         m_state = 0; m_presc = 0; m_t = 0; m_lat = 0; m_wrap = 0;
         return;
      end
      tk = model_tick_now();
      nt = m_t;
      w  = 0;
      if (tk) begin
         if (m_t == MAXT) begin nt = 0; w = 1; end
         else nt = m_t + 1;
      end
      np = ((m_state == 1) || (m_state == 3)) ? (tk ? 0 : m_presc + 1) : m_presc;
      ns = m_state;
      nl = m_lat;
      case (m_state)
         0: if (clr) ns = 0; else if (ss) ns = 1;
         1: if (ss) ns = 2; else if (lp) begin ns = 3; nl = nt; end
         3: if (ss) ns = 2; else if (lp) ns = 1;
         2: if (clr) begin ns = 0; np = 0; nt = 0; nl = 0; end else if (ss) ns = 1;
         default: ns = 0;
      endcase
      m_state = ns; m_presc = np; m_t = nt; m_lat = nl; m_wrap = w;
      m_wraps += w;
   endtask

   // Compare every output against the model for the current cycle, then drive one cycle of inputs.
   task automatic applyStimulus(input bit rst, input bit ss, input bit lp, input bit clr);
      int disp;
      @(negedge clk);
      disp = (m_state == 3) ? m_lat : m_t;
      checkOutput("state",  o_state,  m_state);
      checkOutput("tick",   o_tick,   model_tick_now());
      checkOutput("tenths", o_tenths, disp % 10);
      checkOutput("sec",    o_sec,    (disp / 10) % 60);
      checkOutput("min",    o_min,    (disp / 600) % 60);
`ifdef STOPWATCH_HOURS_EN
      checkOutput("hour",   o_hour,   disp / 36000);
`endif
      checkOutput("wrap",   o_wrap,   m_wrap);
      if (o_wrap === 1'b1) seen_wraps++;
      i_rst = rst; i_start_stop = ss; i_lap = lp; i_clear = clr;
      @(posedge clk);
      model_step(rst, ss, lp, clr);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_tick_then(input bit ss, input bit lp);
      for (int k = 0; k < 8 && !model_tick_now(); k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (!model_tick_now()) checkOutput("tick_wait", 0, 1);
      else applyStimulus(1'b0, ss, lp, 1'b0);
   endtask

   initial begin
      int r;
      i_rst = 1'b1; i_start_stop = 1'b0; i_lap = 1'b0; i_clear = 1'b0;
      repeat (2) @(posedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Start, run, pause with a held fraction, resume.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(45);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(10);

      // Lap freeze and release, live keeps counting.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      idle(15);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      idle(10);

      // Clear ignored while running; clear from pause returns to IDLE.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      idle(5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);

      // Clear beats start_stop in PAUSE; start_stop and lap coinciding with a tick.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(9);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      idle(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      wait_tick_then(1'b1, 1'b0);
      idle(3);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      wait_tick_then(1'b0, 1'b1);
      idle(6);

      // Random single-pulse traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (r < 1)       applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         else if (r < 9)  applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         else if (r < 17) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         else if (r < 23) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         else             applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Long run through the top-of-range rollover.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      m_wraps = 0;
      seen_wraps = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2 * 36000 + 8);
      checkOutput("wrap_count", seen_wraps, m_wraps);

      // Reset mid-run.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
